// File: rtl/dither_quant_packer_pkg.sv
// Shared constants and helpers for the dithered-pixel quantizer/packer.
// Input words carry four 4-bit pixels with px0 in the MSB nibble.
package dither_quant_packer_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int WORD_W      = 16;
  localparam int PX_PER_WORD = WORD_W / NIBBLE_W;

  function automatic bit bpp_legal(input int bpp);
    return (bpp == 1) || (bpp == 2);
  endfunction

  // Input words per packed output word; an illegal depth falls back to 2 bpp packing.
  function automatic int words_per_out(input int bpp);
    return bpp_legal(bpp) ? (PX_PER_WORD / bpp) : 2;
  endfunction

  function automatic int words_per_line(input int h_active);
    return h_active / PX_PER_WORD;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Keep the top bpp bits of each nibble, packed MSB-first and left-aligned in the word.
  function automatic logic [WORD_W-1:0] quantize(input logic [WORD_W-1:0] w, input int bpp);
    logic [WORD_W-1:0]   r;
    logic [NIBBLE_W-1:0] nib;
    r = '0;
    for (int i = 0; i < PX_PER_WORD; i++) begin
      nib = NIBBLE_W'(w >> (WORD_W - NIBBLE_W * (i + 1)));
      r   = (r << bpp) | WORD_W'(nib >> (NIBBLE_W - bpp));
    end
    return r << (WORD_W - PX_PER_WORD * bpp);
  endfunction

endpackage

// File: rtl/dither_quant_packer_frame_pos_counter.sv
// Frame position tracker: word index within a line and line index within a frame.
// A sof on the advancing word counts that word as position (0,0).
module frame_pos_counter
  import dither_quant_packer_pkg::*;
#(
  parameter int WPL   = 400,
  parameter int LINES = 1200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  input  logic       sof_i,
  output logic [2:0] x_pos_o,
  output logic [2:0] y_pos_o,
  output logic       at_origin_o,
  output logic       eol_o,
  output logic       eof_o
);

  localparam int XW = cnt_w(WPL);
  localparam int YW = cnt_w(LINES);

  logic [XW-1:0] x_q, x_d, x_eff_s;
  logic [YW-1:0] y_q, y_d, y_eff_s;

  // eol/eof describe the word being accepted now, after any sof reload
  always_comb begin
    x_eff_s = sof_i ? '0 : x_q;
    y_eff_s = sof_i ? '0 : y_q;
    eol_o   = (x_eff_s == XW'(WPL - 1));
    eof_o   = eol_o && (y_eff_s == YW'(LINES - 1));
    x_d     = x_q;
    y_d     = y_q;
    if (adv_i) begin
      if (eol_o) begin
        x_d = '0;
        y_d = eof_o ? '0 : (y_eff_s + YW'(1));
      end else begin
        x_d = x_eff_s + XW'(1);
        y_d = y_eff_s;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign at_origin_o = (x_q == '0) && (y_q == '0);
  assign x_pos_o     = 3'(x_q);
  assign y_pos_o     = 3'(y_q);

endmodule

// File: rtl/dither_quant_packer.sv
// Truncates dithered nibbles to BPP bits, packs them into 16-bit words and hands them
// to the panel stage over a one-entry valid/ready output register.
module dither_quant_packer
  import dither_quant_packer_pkg::*;
#(
  parameter int BPP      = 2,
  parameter int H_ACTIVE = 1600,
  parameter int V_ACTIVE = 1200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic [WORD_W-1:0] vin,
  input  logic              vin_valid,
  output logic              vin_ready,
  output logic [2:0]        x_pos,
  output logic [2:0]        y_pos,
  output logic [WORD_W-1:0] pout,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic              pout_eol,
  output logic              pout_eof,
  output logic              sync_err
);

  localparam int K   = words_per_out(BPP);
  localparam int PW  = cnt_w(K);
  localparam int QW  = PX_PER_WORD * BPP;
  localparam int WPL = words_per_line(H_ACTIVE);

  logic [PW-1:0]     phase_q, phase_d, phase_eff_s;
  logic [WORD_W-1:0] acc_q, acc_d, acc_base_s, q_s;
  logic [WORD_W-1:0] pout_q, pout_d;
  logic              pout_valid_q, pout_valid_d;
  logic              eol_q, eol_d, eof_q, eof_d;
  logic              sync_err_q, sync_err_d;
  logic              accept_s, complete_s, at_origin_s, eol_s, eof_s;

  assign vin_ready = !pout_valid_q || pout_ready;
  assign accept_s  = vin_valid && vin_ready;

  frame_pos_counter #(
    .WPL  (WPL),
    .LINES(V_ACTIVE)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst),
    .adv_i      (accept_s),
    .sof_i      (sof),
    .x_pos_o    (x_pos),
    .y_pos_o    (y_pos),
    .at_origin_o(at_origin_s),
    .eol_o      (eol_s),
    .eof_o      (eof_s)
  );

  // sof discards any partial word so the sof word always starts a fresh output word
  always_comb begin
    q_s          = quantize(vin, BPP);
    phase_eff_s  = sof ? '0 : phase_q;
    acc_base_s   = sof ? '0 : acc_q;
    complete_s   = accept_s && (phase_eff_s == PW'(K - 1));
    phase_d      = phase_q;
    acc_d        = acc_q;
    sync_err_d   = sync_err_q;
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    eol_d        = eol_q;
    eof_d        = eof_q;
    if (accept_s) begin
      phase_d = complete_s ? '0 : (phase_eff_s + PW'(1));
      acc_d   = (acc_base_s << QW) | (q_s >> (WORD_W - QW));
      if (sof && ((phase_q != '0) || !at_origin_s)) begin
        sync_err_d = 1'b1;
      end else begin
        sync_err_d = sync_err_q;
      end
    end else begin
      phase_d = phase_q;
      acc_d   = acc_q;
    end
    if (complete_s) begin
      pout_d       = acc_d;
      pout_valid_d = 1'b1;
      eol_d        = eol_s;
      eof_d        = eof_s;
    end else if (pout_ready) begin
      pout_valid_d = 1'b0;
    end else begin
      pout_valid_d = pout_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= '0;
      acc_q        <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign pout_eol   = eol_q;
  assign pout_eof   = eof_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_dither_quant_packer.sv
// Bench for dither_quant_packer: instance 0 at 2 bpp and instance 1 at 1 bpp, both with
// 32x2 frames, checked against a pixel-list reference model.
module tb_dither_quant_packer;

  localparam int WPL = 8;
  localparam int VA  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       sof, vin_valid, vin_ready, pout_ready, pout_valid;
  logic [1:0]       pout_eol, pout_eof, sync_err;
  logic [1:0][15:0] vin, pout;
  logic [1:0][2:0]  x_pos, y_pos;

  int checks = 0;
  int errors = 0;

  int          wc[2];
  int          pq[2][$];
  bit          m_valid[2], m_eol[2], m_eof[2], m_err[2];
  logic [15:0] m_pout[2];

  always #5 clk = ~clk;

  dither_quant_packer #(.BPP(2), .H_ACTIVE(32), .V_ACTIVE(2)) dut2 (
    .clk(clk), .rst(rst), .sof(sof[0]), .vin(vin[0]), .vin_valid(vin_valid[0]),
    .vin_ready(vin_ready[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]), .pout(pout[0]),
    .pout_valid(pout_valid[0]), .pout_ready(pout_ready[0]), .pout_eol(pout_eol[0]),
    .pout_eof(pout_eof[0]), .sync_err(sync_err[0])
  );

  dither_quant_packer #(.BPP(1), .H_ACTIVE(32), .V_ACTIVE(2)) dut1 (
    .clk(clk), .rst(rst), .sof(sof[1]), .vin(vin[1]), .vin_valid(vin_valid[1]),
    .vin_ready(vin_ready[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]), .pout(pout[1]),
    .pout_valid(pout_valid[1]), .pout_ready(pout_ready[1]), .pout_eol(pout_eol[1]),
    .pout_eof(pout_eof[1]), .sync_err(sync_err[1])
  );

  function automatic int bpp_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input int d, input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      wc[d]      = 0;
      pq[d].delete();
      m_valid[d] = 1'b0;
      m_eol[d]   = 1'b0;
      m_eof[d]   = 1'b0;
      m_err[d]   = 1'b0;
      m_pout[d]  = 16'h0000;
    end
  endtask

  // One clock of stimulus on instance d; called at posedge+1, returns at posedge+1
  task automatic step(input int d, input logic v, input logic [15:0] w, input logic s, input logic r);
    bit          acc, done;
    int          bpp, pos, ppw;
    logic [15:0] word;
    bpp           = bpp_of(d);
    ppw           = 16 / bpp;
    vin_valid[d]  = v;
    vin[d]        = w;
    sof[d]        = s;
    pout_ready[d] = r;
    #4;
    check(d, "vin_ready", {15'h0000, vin_ready[d]}, {15'h0000, !m_valid[d] || r});
    acc = v && (!m_valid[d] || r);
    @(posedge clk);
    #1;
    done = 1'b0;
    if (acc) begin
      if (s) begin
        if (pq[d].size() != 0 || wc[d] != 0) m_err[d] = 1'b1;
        pq[d].delete();
        wc[d] = 0;
      end
      pos = wc[d];
      for (int i = 0; i < 4; i++)
        pq[d].push_back(int'(((w >> (12 - 4 * i)) & 16'h000F) >> (4 - bpp)));
      wc[d] = (wc[d] + 1) % (WPL * VA);
      if (pq[d].size() == ppw) begin
        word = 16'h0000;
        for (int k = 0; k < ppw; k++) word = word * (16'h0001 << bpp) + 16'(pq[d][k]);
        pq[d].delete();
        done      = 1'b1;
        m_pout[d] = word;
        m_eol[d]  = (pos % WPL) == (WPL - 1);
        m_eof[d]  = pos == (WPL * VA - 1);
      end
    end
    if (done) m_valid[d] = 1'b1;
    else if (r) m_valid[d] = 1'b0;
    check(d, "pout_valid", {15'h0000, pout_valid[d]}, {15'h0000, m_valid[d]});
    if (m_valid[d]) begin
      check(d, "pout", pout[d], m_pout[d]);
      check(d, "pout_eol", {15'h0000, pout_eol[d]}, {15'h0000, m_eol[d]});
      check(d, "pout_eof", {15'h0000, pout_eof[d]}, {15'h0000, m_eof[d]});
    end
    check(d, "x_pos", {13'h0000, x_pos[d]}, 16'((wc[d] % WPL) % 8));
    check(d, "y_pos", {13'h0000, y_pos[d]}, 16'((wc[d] / WPL) % 8));
    check(d, "sync_err", {15'h0000, sync_err[d]}, {15'h0000, m_err[d]});
    vin_valid[d]  = 1'b0;
    sof[d]        = 1'b0;
    pout_ready[d] = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    sof        = 2'b00;
    vin_valid  = 2'b00;
    pout_ready = 2'b00;
    vin        = '0;
    reset_model();
    #12;
    for (int d = 0; d < 2; d++) begin
      check(d, "rst_vin_ready", {15'h0000, vin_ready[d]}, 16'h0001);
      check(d, "rst_pout_valid", {15'h0000, pout_valid[d]}, 16'h0000);
      check(d, "rst_pout", pout[d], 16'h0000);
      check(d, "rst_eol_eof", {14'h0000, pout_eol[d], pout_eof[d]}, 16'h0000);
      check(d, "rst_xy", {10'h000, x_pos[d], y_pos[d]}, 16'h0000);
      check(d, "rst_sync_err", {15'h0000, sync_err[d]}, 16'h0000);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1 bpp: four input words fill one output word
    step(1, 1'b1, 16'h8888, 1'b1, 1'b1);
    step(1, 1'b1, 16'h0000, 1'b0, 1'b1);
    step(1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    check(1, "bpp1_not_yet", {15'h0000, pout_valid[1]}, 16'h0000);
    step(1, 1'b1, 16'h7777, 1'b0, 1'b1);
    check(1, "bpp1_word", pout[1], 16'hF0F0);
    step(1, 1'b0, 16'h0000, 1'b0, 1'b1);

    // 2 bpp: px 3,2,1,0 then 0,3,2,0
    step(0, 1'b1, 16'hFA50, 1'b1, 1'b1);
    check(0, "bpp2_not_yet", {15'h0000, pout_valid[0]}, 16'h0000);
    step(0, 1'b1, 16'h3C81, 1'b0, 1'b1);
    check(0, "bpp2_word", pout[0], 16'hE438);

    // rest of the frame: eol on outputs 4 and 8, eof on 8
    for (int i = 0; i < 14; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b1);
    check(0, "frame_eof", {14'h0000, pout_eol[0], pout_eof[0]}, 16'h0003);
    step(0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // sof after one word of a pair
    step(0, 1'b1, 16'($urandom), 1'b1, 1'b1);
    step(0, 1'b1, 16'($urandom), 1'b1, 1'b1);
    check(0, "sof_err", {15'h0000, sync_err[0]}, 16'h0001);
    check(0, "sof_xy", {10'h000, x_pos[0], y_pos[0]}, 16'h0008);

    // backpressure then release
    for (int i = 0; i < 5; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    check(0, "bp_full", {15'h0000, vin_ready[0]}, 16'h0000);
    for (int i = 0; i < 6; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b1);

    // randomized traffic on both instances
    for (int i = 0; i < 120; i++)
      step(0, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0);
    for (int i = 0; i < 120; i++)
      step(1, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 23) == 0,
           $urandom_range(0, 3) != 0);

    // asynchronous reset with the output register full
    for (int i = 0; i < 3; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    check(0, "pre_rst_valid", {15'h0000, pout_valid[0]}, 16'h0001);
    rst = 1'b0;
    #1;
    check(0, "arst_pout_valid", {15'h0000, pout_valid[0]}, 16'h0000);
    check(0, "arst_vin_ready", {15'h0000, vin_ready[0]}, 16'h0001);
    check(0, "arst_xy", {10'h000, x_pos[0], y_pos[0]}, 16'h0000);
    check(0, "arst_sync_err", {15'h0000, sync_err[0]}, 16'h0000);
    #2;
    rst = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
